rom_download_ctrl: RTL

Sits between the hps_io ioctl download stream and the DDR3/SDRAM ROM writers.
- Accepts 16-bit ROM words and applies the optional bit-reversal swap.
- Issues toggle-handshake writes to both memory writers and stalls hps_io via ioctl_wait until both acknowledge.
- At end of download, reports ROM size, 512-byte header presence, Populous signature flags and SGX mode to pce_top and the memory read path.

---
 rtl/pce_rom_pkg.sv | 30 +++
 rtl/pop_sig_detect.sv | 37 +++
 rtl/rom_download_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pce_rom_pkg.sv
// Shared types and constants for the PCE ROM download path.
// Optional feature macro: ROM_CHECKSUM_EN (adds the rom_sum output to rom_download_ctrl).
package pce_rom_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        WAIT_ACK = 2'd2,
        FINISH   = 2'd3
    } state_t;

    // "POPULOUS" words expected at offsets 6, 8, 10 and 12 of a signature block
    localparam logic [3:0][15:0] POP_SIG = {16'h5355, 16'h4F4C, 16'h5550, 16'h4F50};

    // Signature block bases, compared against addr[ADDR_W-1:4]
    localparam logic [11:0] POP_BASE_HI = 12'h212;
    localparam logic [11:0] POP_BASE_LO = 12'h1F2;

    localparam int unsigned HDR_SIZE_DEF = 512;

    function automatic logic [15:0] bit_rev_bytes(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = d[7-i];
            r[8+i]   = d[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pop_sig_detect.sv
// Populous signature checker: flags which 8 KB half saw a mismatching signature word.
module pop_sig_detect
    import pce_rom_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data,
    input  logic              valid,
    output logic [1:0]        clr_mask_c
);

    localparam int unsigned BASE_W = ADDR_W - 4;

    logic        base_hit;
    logic        sig_slot;
    logic [15:0] exp_sig;

    always_comb begin
        clr_mask_c = 2'b00;
        base_hit   = (addr[ADDR_W-1:4] == BASE_W'(POP_BASE_HI)) ||
                     (addr[ADDR_W-1:4] == BASE_W'(POP_BASE_LO));
        sig_slot   = 1'b1;
        exp_sig    = 16'h0000;
        case (addr[3:0])
            4'd6:    exp_sig = POP_SIG[0];
            4'd8:    exp_sig = POP_SIG[1];
            4'd10:   exp_sig = POP_SIG[2];
            4'd12:   exp_sig = POP_SIG[3];
            default: sig_slot = 1'b0;
        endcase
        if (valid && base_hit && sig_slot && (data != exp_sig)) begin
            clr_mask_c[addr[13]] = 1'b1;
        end
    end

endmodule

// File: rtl/rom_download_ctrl.sv
// ioctl ROM download controller: toggle-handshake writes to DDR3/SDRAM writers plus end-of-load info.
// Optional feature macro: ROM_CHECKSUM_EN adds rom_sum (byte sum of accepted words).
module rom_download_ctrl
    import pce_rom_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned HDR_SIZE  = HDR_SIZE_DEF,
    parameter int unsigned SGX_INDEX = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    input  logic              swap,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_req,
    input  logic              dd_ack,
    input  logic              sd_ack,
    output logic [ADDR_W-1:0] rom_size,
    output logic              hdr_present,
    output logic [1:0]        populous,
    output logic              sgx,
`ifdef ROM_CHECKSUM_EN
    output logic [15:0]       rom_sum,
`endif
    output logic              done
);

    state_t            state, state_nxt;
    logic              dl_q, start_pend, start_pend_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt, rom_size_nxt;
    logic [15:0]       wr_data_nxt, din_sw;
    logic              wr_req_nxt, wait_nxt, hdr_nxt, sgx_nxt, done_nxt;
    logic [1:0]        populous_nxt, pop_clr_c;
    logic              rise_c, accept_c, ack_ok_c;
    logic              unused_idx_c;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]       rom_sum_nxt;
`endif

    assign unused_idx_c = ^ioctl_index[7:5];
    assign rise_c       = ioctl_download & ~dl_q;
    assign accept_c     = (state == ACTIVE) && ioctl_wr;
    assign ack_ok_c     = (dd_ack == wr_req) && (sd_ack == wr_req);
    assign din_sw       = swap ? bit_rev_bytes(ioctl_dout) : ioctl_dout;

    pop_sig_detect #(.ADDR_W(ADDR_W)) u_pop (
        .addr       (wr_addr),
        .data       (din_sw),
        .valid      (accept_c),
        .clr_mask_c (pop_clr_c)
    );

    // Next-state and output logic
    always_comb begin
        state_nxt      = state;
        start_pend_nxt = start_pend | (rise_c && (state != IDLE));
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        wr_req_nxt     = wr_req;
        wait_nxt       = ioctl_wait;
        rom_size_nxt   = rom_size;
        hdr_nxt        = hdr_present;
        populous_nxt   = populous;
        sgx_nxt        = sgx;
        done_nxt       = 1'b0;
`ifdef ROM_CHECKSUM_EN
        rom_sum_nxt    = rom_sum;
`endif
        case (state)
            IDLE: begin
                start_pend_nxt = 1'b0;
                if (rise_c || start_pend) begin
                    wr_addr_nxt  = '0;
                    populous_nxt = 2'b11;
                    sgx_nxt      = (ioctl_index[4:0] == 5'(SGX_INDEX));
`ifdef ROM_CHECKSUM_EN
                    rom_sum_nxt  = 16'h0000;
`endif
                    state_nxt    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ioctl_wr) begin
                    wr_data_nxt  = din_sw;
                    wr_req_nxt   = ~wr_req;
                    wait_nxt     = 1'b1;
                    populous_nxt = populous & ~pop_clr_c;
`ifdef ROM_CHECKSUM_EN
                    rom_sum_nxt  = rom_sum + 16'(din_sw[7:0]) + 16'(din_sw[15:8]);
`endif
                    state_nxt    = WAIT_ACK;
                end else if (!ioctl_download) begin
                    state_nxt = FINISH;
                end
            end
            WAIT_ACK: begin
                // A pending write always completes before an end of download is honoured
                if (ack_ok_c) begin
                    wait_nxt    = 1'b0;
                    wr_addr_nxt = wr_addr + ADDR_W'(2);
                    state_nxt   = ioctl_download ? ACTIVE : FINISH;
                end
            end
            FINISH: begin
                rom_size_nxt = wr_addr;
                hdr_nxt      = (wr_addr[12:0] == 13'(HDR_SIZE));
                done_nxt     = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dl_q        <= 1'b0;
            start_pend  <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 16'h0000;
            wr_req      <= 1'b0;
            ioctl_wait  <= 1'b0;
            rom_size    <= '0;
            hdr_present <= 1'b0;
            populous    <= 2'b11;
            sgx         <= 1'b0;
            done        <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            rom_sum     <= 16'h0000;
`endif
        end else begin
            state       <= state_nxt;
            dl_q        <= ioctl_download;
            start_pend  <= start_pend_nxt;
            wr_addr     <= wr_addr_nxt;
            wr_data     <= wr_data_nxt;
            wr_req      <= wr_req_nxt;
            ioctl_wait  <= wait_nxt;
            rom_size    <= rom_size_nxt;
            hdr_present <= hdr_nxt;
            populous    <= populous_nxt;
            sgx         <= sgx_nxt;
            done        <= done_nxt;
`ifdef ROM_CHECKSUM_EN
            rom_sum     <= rom_sum_nxt;
`endif
        end
    end

endmodule
